// File: rtl/tlp_stream_arbiter.sv
// Packet-atomic round-robin arbiter: posted (s0) and non-posted (s1) AXI-Stream queues onto one bridge input.
// Latency: 1 cycle to grant from IDLE; 0-cycle combinational data path and tready path while granted.
// Backpressure: m_axis_tready passes straight to the owner; the loser sees tready=0. Watchdog: TLP_ARB_WATCHDOG_EN.
module tlp_stream_arbiter #(
  parameter int DATA_WDTH = 64,
  parameter int KEEP_WDTH = 8,
  parameter int MAX_BEATS = 514
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s0_axis_tvalid,
  output logic                 s0_axis_tready,
  input  logic [DATA_WDTH-1:0] s0_axis_tdata,
  input  logic [KEEP_WDTH-1:0] s0_axis_tkeep,
  input  logic                 s0_axis_tlast,
  input  logic                 s1_axis_tvalid,
  output logic                 s1_axis_tready,
  input  logic [DATA_WDTH-1:0] s1_axis_tdata,
  input  logic [KEEP_WDTH-1:0] s1_axis_tkeep,
  input  logic                 s1_axis_tlast,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic [DATA_WDTH-1:0] m_axis_tdata,
  output logic [KEEP_WDTH-1:0] m_axis_tkeep,
  output logic                 m_axis_tlast,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic                 trunc_err
);

  // Catch illegal configurations at elaboration rather than in silicon.
  if (MAX_BEATS < 2 || MAX_BEATS > 1023) begin : g_bad_max_beats
    $error("tlp_stream_arbiter: MAX_BEATS must be in 2..1023");
  end
  if (KEEP_WDTH * 8 != DATA_WDTH) begin : g_bad_keep_wdth
    $error("tlp_stream_arbiter: KEEP_WDTH must equal DATA_WDTH/8");
  end

`ifdef TLP_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;
  localparam logic [9:0] CNT_LIMIT = 10'(MAX_BEATS - 1);
  logic [9:0] beat_cnt;
`else
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
`endif

  state_t state;
  logic   last_gnt;   // index of the most recently granted source
  logic   m_hs;       // beat accepted by the bridge
  logic   src_last;   // owner's own tlast, before any watchdog forcing
  logic   at_limit;   // current beat is the last one the watchdog allows
  logic   own_vld;    // owner's tvalid while draining
  logic   own_last;   // owner's tlast while draining

  assign m_hs     = m_axis_tvalid & m_axis_tready;
  assign src_last = (state == GNT1) ? s1_axis_tlast : s0_axis_tlast;
  assign own_vld  = last_gnt ? s1_axis_tvalid : s0_axis_tvalid;
  assign own_last = last_gnt ? s1_axis_tlast : s0_axis_tlast;

`ifdef TLP_ARB_WATCHDOG_EN
  assign at_limit = (beat_cnt == CNT_LIMIT);
`else
  assign at_limit  = 1'b0;
  assign trunc_err = 1'b0;
`endif

  // Combinational mux: owner's stream passes straight through; everything else is quiet.
  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tkeep   = '0;
    m_axis_tlast   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    case (state)
      GNT0: begin
        m_axis_tvalid  = s0_axis_tvalid;
        m_axis_tdata   = s0_axis_tdata;
        m_axis_tkeep   = s0_axis_tkeep;
        m_axis_tlast   = s0_axis_tlast | at_limit;
        s0_axis_tready = m_axis_tready;
      end
      GNT1: begin
        m_axis_tvalid  = s1_axis_tvalid;
        m_axis_tdata   = s1_axis_tdata;
        m_axis_tkeep   = s1_axis_tkeep;
        m_axis_tlast   = s1_axis_tlast | at_limit;
        s1_axis_tready = m_axis_tready;
      end
`ifdef TLP_ARB_WATCHDOG_EN
      DRAIN: begin
        // Swallow the rest of the runaway packet without showing it to the bridge.
        if (last_gnt) s1_axis_tready = 1'b1;
        else          s0_axis_tready = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Arbitration FSM with registered grant/busy/trunc_err; grant is held until the owner's tlast.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      grant    <= 2'b00;
      busy     <= 1'b0;
`ifdef TLP_ARB_WATCHDOG_EN
      trunc_err <= 1'b0;
      beat_cnt  <= '0;
`endif
    end else begin
`ifdef TLP_ARB_WATCHDOG_EN
      trunc_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // On a tie, the source not granted last time wins.
          if (s0_axis_tvalid && (!s1_axis_tvalid || last_gnt)) begin
            state    <= GNT0;
            last_gnt <= 1'b0;
            grant    <= 2'b01;
            busy     <= 1'b1;
`ifdef TLP_ARB_WATCHDOG_EN
            beat_cnt <= '0;
`endif
          end else if (s1_axis_tvalid) begin
            state    <= GNT1;
            last_gnt <= 1'b1;
            grant    <= 2'b10;
            busy     <= 1'b1;
`ifdef TLP_ARB_WATCHDOG_EN
            beat_cnt <= '0;
`endif
          end
        end
        GNT0, GNT1: begin
          if (m_hs) begin
            if (src_last) begin
              state <= IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
`ifdef TLP_ARB_WATCHDOG_EN
            end else if (at_limit) begin
              // Packet cut short: the forced tlast already went out on this beat.
              state     <= DRAIN;
              trunc_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 10'd1;
`endif
            end
          end
        end
`ifdef TLP_ARB_WATCHDOG_EN
        DRAIN: begin
          if (own_vld && own_last) begin
            state <= IDLE;
            grant <= 2'b00;
            busy  <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlp_stream_arbiter.sv
// Directed bench for tlp_stream_arbiter: reset, round-robin, backpressure, no-interleave, watchdog, reset mid-packet.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Source queues model the upstream FIFOs; every accepted m_axis beat is logged with its cycle number.
module tb_tlp_stream_arbiter;

  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
  logic [63:0] s0_axis_tdata;
  logic [7:0]  s0_axis_tkeep;
  logic        s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
  logic [63:0] s1_axis_tdata;
  logic [7:0]  s1_axis_tkeep;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic [1:0]  grant;
  logic        busy, trunc_err;

  beat_t q0[$];
  beat_t q1[$];
  beat_t log_q[$];
  int    log_cyc[$];
  logic  en0, en1;
  bit    hs0, hs1;
  int    cyc;
  int    trunc_cnt;
  int    drain_cnt;
  int    n_cmp;
  int    n_bad;

  always #5 clk = ~clk;

  tlp_stream_arbiter #(.DATA_WDTH(64), .KEEP_WDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .reset(reset),
    .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep), .s0_axis_tlast(s0_axis_tlast),
    .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep), .s1_axis_tlast(s1_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .grant(grant), .busy(busy), .trunc_err(trunc_err)
  );

  function automatic logic [63:0] exp_data(input int src, input int pkt, input int beat);
    return 64'hA000_0000_0000_0000 | 64'(src << 16) | 64'(pkt << 8) | 64'(beat);
  endfunction

  task automatic add_pkt(input int src, input int pkt, input int n);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.data = exp_data(src, pkt, i);
      b.last = (i == n - 1);
      b.keep = (i == n - 1) ? 8'h0F : 8'hFF;
      if (src == 0) q0.push_back(b);
      else          q1.push_back(b);
    end
  endtask

  task automatic drive_srcs();
    s0_axis_tvalid = en0 && (q0.size() > 0);
    s0_axis_tdata  = (q0.size() > 0) ? q0[0].data : 64'h0;
    s0_axis_tkeep  = (q0.size() > 0) ? q0[0].keep : 8'h0;
    s0_axis_tlast  = (q0.size() > 0) ? q0[0].last : 1'b0;
    s1_axis_tvalid = en1 && (q1.size() > 0);
    s1_axis_tdata  = (q1.size() > 0) ? q1[0].data : 64'h0;
    s1_axis_tkeep  = (q1.size() > 0) ? q1[0].keep : 8'h0;
    s1_axis_tlast  = (q1.size() > 0) ? q1[0].last : 1'b0;
  endtask

  // Apply inputs, then sample everything on the falling edge.
  task automatic settle();
    beat_t b;
    drive_srcs();
    @(negedge clk);
    hs0 = s0_axis_tvalid && s0_axis_tready;
    hs1 = s1_axis_tvalid && s1_axis_tready;
    if (m_axis_tvalid && m_axis_tready) begin
      b.last = m_axis_tlast;
      b.keep = m_axis_tkeep;
      b.data = m_axis_tdata;
      log_q.push_back(b);
      log_cyc.push_back(cyc);
    end else if (hs0 || hs1) begin
      drain_cnt++;
    end
    if (trunc_err) trunc_cnt++;
  endtask

  // Cross the rising edge and retire the beats the sources handed over.
  task automatic advance();
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    hs0 = 1'b0;
    hs1 = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q0.delete(); q1.delete(); log_q.delete(); log_cyc.delete();
    en0 = 1'b0; en1 = 1'b0; m_axis_tready = 1'b1;
    hs0 = 1'b0; hs1 = 1'b0; trunc_cnt = 0; drain_cnt = 0;
    drive_srcs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic run_until_empty(input string name, input int max_cyc);
    int k;
    for (k = 0; k < max_cyc; k++) begin
      settle();
      advance();
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: q0=%0d q1=%0d beats left, required 0", name, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    q0.delete(); q1.delete(); log_q.delete(); log_cyc.delete();
    add_pkt(0, 0, 1); add_pkt(1, 0, 1);
    en0 = 1'b1; en1 = 1'b1; m_axis_tready = 1'b1;
    settle();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_grant: got %b want 00", grant); end
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_mvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin n_bad++; $display("FAIL rst_tready: got %b want 00", {s0_axis_tready, s1_axis_tready}); end
    n_cmp++; if ({busy, trunc_err} !== 2'b00) begin n_bad++; $display("FAIL rst_busy_trunc: got %b want 00", {busy, trunc_err}); end
    @(posedge clk); #1; reset = 1'b1;
    settle();
    n_cmp++; if (grant !== 2'b00) begin n_bad++; $display("FAIL rst_release_idle: got %b want 00", grant); end
    advance();
    settle();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rst_first_grant: got %b want 01", grant); end
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data(0, 0, 0)) begin n_bad++; $display("FAIL rst_first_beat: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, exp_data(0, 0, 0)); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_busy_granted: got %b want 1", busy); end
    advance();
    run_until_empty("rst", 20);
    n_cmp++; if (log_q.size() != 2 || log_q[1].data !== exp_data(1, 0, 0)) begin n_bad++; $display("FAIL rst_order: got %0d beats, want 2 with s1 second", log_q.size()); end
  endtask

  task automatic test_round_robin();
    int exp_off[12] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 12, 13, 14};
    int exp_src[4]  = '{0, 1, 0, 1};
    int exp_pkt[4]  = '{0, 0, 1, 1};
    do_reset();
    add_pkt(0, 0, 3); add_pkt(0, 1, 3); add_pkt(1, 0, 3); add_pkt(1, 1, 3);
    en0 = 1'b1; en1 = 1'b1;
    run_until_empty("rr", 40);
    n_cmp++;
    if (log_q.size() != 12) begin
      n_bad++; $display("FAIL rr_count: got %0d beats want 12", log_q.size());
    end else begin
      for (int i = 0; i < 12; i++) begin
        n_cmp++;
        if (log_q[i].data !== exp_data(exp_src[i/3], exp_pkt[i/3], i % 3) || log_q[i].last !== (i % 3 == 2)) begin
          n_bad++; $display("FAIL rr_beat%0d: got d=%h l=%b want d=%h l=%b", i, log_q[i].data, log_q[i].last, exp_data(exp_src[i/3], exp_pkt[i/3], i % 3), (i % 3 == 2));
        end
        n_cmp++;
        if (log_cyc[i] - log_cyc[0] != exp_off[i]) begin
          n_bad++; $display("FAIL rr_timing%0d: got offset %0d want %0d", i, log_cyc[i] - log_cyc[0], exp_off[i]);
        end
      end
      n_cmp++; if (log_q[2].keep !== 8'h0F || log_q[0].keep !== 8'hFF) begin n_bad++; $display("FAIL rr_keep: got %h/%h want FF/0F", log_q[0].keep, log_q[2].keep); end
    end
  endtask

  task automatic test_backpressure();
    int k;
    do_reset();
    add_pkt(1, 0, 4); add_pkt(0, 0, 2);
    en1 = 1'b1;
    for (k = 0; k < 40; k++) begin
      m_axis_tready = (k % 2 == 0);
      settle();
      if (grant == 2'b10) begin
        n_cmp++; if (s1_axis_tready !== m_axis_tready) begin n_bad++; $display("FAIL bp_s1_tready_k%0d: got %b want %b", k, s1_axis_tready, m_axis_tready); end
        n_cmp++; if (s0_axis_tready !== 1'b0) begin n_bad++; $display("FAIL bp_s0_tready_k%0d: got %b want 0", k, s0_axis_tready); end
      end
      if (k == 1) en0 = 1'b1;
      advance();
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    n_cmp++; if (q0.size() != 0 || q1.size() != 0) begin n_bad++; $display("FAIL bp_timeout: q0=%0d q1=%0d want 0", q0.size(), q1.size()); end
    n_cmp++;
    if (log_q.size() != 6) begin
      n_bad++; $display("FAIL bp_count: got %0d beats want 6", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_q[i].data !== exp_data(1, 0, i) || log_q[i].last !== (i == 3)) begin
          n_bad++; $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b", i, log_q[i].data, log_q[i].last, exp_data(1, 0, i), (i == 3));
        end
      end
      n_cmp++; if (log_q[4].data !== exp_data(0, 0, 0)) begin n_bad++; $display("FAIL bp_s0_after: got %h want %h", log_q[4].data, exp_data(0, 0, 0)); end
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_no_interleave();
    int k;
    int drop_left;
    bit dropped;
    drop_left = 0; dropped = 1'b0;
    do_reset();
    add_pkt(0, 0, 5); add_pkt(1, 0, 2);
    en1 = 1'b1;
    for (k = 0; k < 60; k++) begin
      en0 = (drop_left == 0);
      settle();
      if (drop_left > 0) begin
        n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL ni_grant_k%0d: got %b want 01", k, grant); end
        n_cmp++; if (s1_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL ni_quiet_k%0d: got s1r=%b mv=%b want 0 0", k, s1_axis_tready, m_axis_tvalid); end
        drop_left--;
      end
      if (!dropped && log_q.size() == 2) begin
        dropped = 1'b1; drop_left = 5;
      end
      advance();
      if (q0.size() == 0 && q1.size() == 0) break;
    end
    n_cmp++; if (q0.size() != 0 || q1.size() != 0) begin n_bad++; $display("FAIL ni_timeout: q0=%0d q1=%0d want 0", q0.size(), q1.size()); end
    n_cmp++;
    if (log_q.size() != 7) begin
      n_bad++; $display("FAIL ni_count: got %0d beats want 7", log_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (log_q[i].data !== ((i < 5) ? exp_data(0, 0, i) : exp_data(1, 0, i - 5))) begin
          n_bad++; $display("FAIL ni_beat%0d: got %h want %h", i, log_q[i].data, (i < 5) ? exp_data(0, 0, i) : exp_data(1, 0, i - 5));
        end
      end
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    add_pkt(0, 0, 7);
    en0 = 1'b1;
    run_until_empty("wd", 40);
    settle();
    n_cmp++; if (busy !== 1'b0 || grant !== 2'b00) begin n_bad++; $display("FAIL wd_idle: got busy=%b grant=%b want 0 00", busy, grant); end
`ifdef TLP_ARB_WATCHDOG_EN
    n_cmp++; if (trunc_cnt != 1) begin n_bad++; $display("FAIL wd_trunc_pulses: got %0d want 1", trunc_cnt); end
    n_cmp++; if (drain_cnt != 3) begin n_bad++; $display("FAIL wd_drained: got %0d want 3", drain_cnt); end
    n_cmp++;
    if (log_q.size() != 4) begin
      n_bad++; $display("FAIL wd_count: got %0d beats want 4", log_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (log_q[i].data !== exp_data(0, 0, i) || log_q[i].last !== (i == 3)) begin
          n_bad++; $display("FAIL wd_beat%0d: got d=%h l=%b want d=%h l=%b", i, log_q[i].data, log_q[i].last, exp_data(0, 0, i), (i == 3));
        end
      end
    end
`else
    n_cmp++; if (trunc_cnt != 0) begin n_bad++; $display("FAIL wd_trunc_pulses: got %0d want 0", trunc_cnt); end
    n_cmp++;
    if (log_q.size() != 7) begin
      n_bad++; $display("FAIL wd_count: got %0d beats want 7", log_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++;
        if (log_q[i].data !== exp_data(0, 0, i) || log_q[i].last !== (i == 6)) begin
          n_bad++; $display("FAIL wd_beat%0d: got d=%h l=%b want d=%h l=%b", i, log_q[i].data, log_q[i].last, exp_data(0, 0, i), (i == 6));
        end
      end
    end
`endif
    advance();
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    add_pkt(1, 0, 5);
    en1 = 1'b1;
    for (k = 0; k < 10; k++) begin
      settle();
      if (log_q.size() == 2) break;
      advance();
    end
    n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_data(1, 0, 1)) begin n_bad++; $display("FAIL rm_beat2: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, exp_data(1, 0, 1)); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rm_async_mvalid: got %b want 0", m_axis_tvalid); end
    n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_bad++; $display("FAIL rm_async_grant: got grant=%b busy=%b want 00 0", grant, busy); end
    n_cmp++; if (s1_axis_tready !== 1'b0) begin n_bad++; $display("FAIL rm_async_tready: got %b want 0", s1_axis_tready); end
    q0.delete(); q1.delete(); log_q.delete(); log_cyc.delete();
    hs0 = 1'b0; hs1 = 1'b0;
    add_pkt(0, 0, 1); add_pkt(1, 1, 1);
    en0 = 1'b1; en1 = 1'b1;
    drive_srcs();
    @(posedge clk); #1; reset = 1'b1;
    settle();
    advance();
    settle();
    n_cmp++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rm_tie_grant: got %b want 01", grant); end
    n_cmp++; if (m_axis_tdata !== exp_data(0, 0, 0)) begin n_bad++; $display("FAIL rm_tie_data: got %h want %h", m_axis_tdata, exp_data(0, 0, 0)); end
    advance();
    run_until_empty("rm", 20);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b0; en0 = 1'b0; en1 = 1'b0; m_axis_tready = 1'b0;
    hs0 = 1'b0; hs1 = 1'b0; trunc_cnt = 0; drain_cnt = 0;
    drive_srcs();
    test_reset();
    test_round_robin();
    test_backpressure();
    test_no_interleave();
    test_watchdog();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
